// File: rtl/mem_fifo_ctrl.sv
// Push/pop FIFO controller in front of a single-port RAM with synchronous write and
// asynchronous read. At most one RAM access per clock; pop wins when the FIFO is non-empty.
module mem_fifo_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ack,
  input  logic              pop,
  output logic              pop_ack,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              pop_valid_q;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;

  // Arbitration and RAM drive
  always_comb begin
    pop_ack  = pop & ~empty_q;
    push_ack = push & ~full_q & ~pop_ack;
    mem_adr  = push_ack ? wr_ptr_q : rd_ptr_q;
    // Gate with reset so an in-flight push cannot corrupt the RAM while reset is held.
    mem_we   = push_ack & ~rst;
    mem_din  = push_data;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;
    if (pop_ack) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      count_d    = count_q - (ADDR_W + 1)'(1);
      pop_data_d = mem_dout;
    end else if (push_ack) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = count_q + (ADDR_W + 1)'(1);
    end
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      pop_valid_q <= pop_ack;
      pop_data_q  <= pop_data_d;
    end
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: bench-side 128x8 RAM, queue-based FIFO model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_fifo_ctrl;

  logic       ck;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       push_ack;
  logic       pop;
  logic       pop_ack;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       full;
  logic       empty;
  logic [7:0] count;
  logic [6:0] mem_adr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;

  int total = 0;
  int bad   = 0;

  mem_fifo_ctrl #(
    .ADDR_W(7),
    .DATA_W(8)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .push_ack (push_ack),
    .pop      (pop),
    .pop_ack  (pop_ack),
    .pop_data (pop_data),
    .pop_valid(pop_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .mem_adr  (mem_adr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // RAM: synchronous write, asynchronous read
  logic [7:0] ram [128];
  always @(posedge ck) if (mem_we) ram[mem_adr] <= mem_din;
  assign mem_dout = ram[mem_adr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, addresses from running push/pop totals.
  logic [7:0] q[$];
  int         n_push, n_pop;
  logic       m_pv;
  logic [7:0] m_pd;
  logic       e_pop, e_push;
  logic [7:0] popped;

  task automatic model_reset();
    q.delete();
    n_push = 0;
    n_pop  = 0;
    m_pv   = 1'b0;
    m_pd   = 8'd0;
  endtask

  initial model_reset();

  always begin
    @(negedge ck);
    if (rst) model_reset();
    e_pop  = pop && (q.size() != 0);
    e_push = push && (q.size() != 128) && !e_pop;
    check("pop_ack", 32'(pop_ack), 32'(e_pop));
    check("push_ack", 32'(push_ack), 32'(e_push));
    check("mem_we", 32'(mem_we), 32'(e_push && !rst));
    check("mem_adr", 32'(mem_adr), e_push ? 32'(n_push % 128) : 32'(n_pop % 128));
    check("mem_din", 32'(mem_din), 32'(push_data));
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == 128));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("pop_valid", 32'(pop_valid), 32'(m_pv));
    check("pop_data", 32'(pop_data), 32'(m_pd));
    @(posedge ck);
    if (rst) begin
      model_reset();
    end else begin
      m_pv = e_pop;
      if (e_pop) begin
        popped = q.pop_front();
        m_pd   = popped;
        n_pop++;
      end
      if (e_push) begin
        q.push_back(push_data);
        n_push++;
      end
    end
  end

  logic       s_pa, s_oa, s_we;
  logic [6:0] s_adr;

  // Drive one cycle of requests; sample combinational outputs mid-cycle, return after the edge.
  task automatic step(input logic p, input logic [7:0] d, input logic o);
    push      = p;
    push_data = d;
    pop       = o;
    #3;
    s_pa  = push_ack;
    s_oa  = pop_ack;
    s_we  = mem_we;
    s_adr = mem_adr;
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    push_data = 8'd0;
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);

    // Three pushes land at addresses 0,1,2
    step(1'b1, 8'd22, 1'b0);
    check("push0_adr", 32'(s_adr), 32'd0);
    check("push0_we", 32'(s_we), 32'd1);
    step(1'b1, 8'd44, 1'b0);
    check("push1_adr", 32'(s_adr), 32'd1);
    step(1'b1, 8'd66, 1'b0);
    check("push2_adr", 32'(s_adr), 32'd2);
    check("push3_count", 32'(count), 32'd3);
    check("push3_empty", 32'(empty), 32'd0);

    step(1'b0, 8'd0, 1'b1);
    check("pop0_valid", 32'(pop_valid), 32'd1);
    check("pop0_data", 32'(pop_data), 32'd22);
    step(1'b0, 8'd0, 1'b1);
    check("pop1_data", 32'(pop_data), 32'd44);
    step(1'b0, 8'd0, 1'b1);
    check("pop2_data", 32'(pop_data), 32'd66);
    check("pop3_empty", 32'(empty), 32'd1);
    step(1'b0, 8'd0, 1'b0);
    check("pop_valid_drop", 32'(pop_valid), 32'd0);
    check("pop_data_hold", 32'(pop_data), 32'd66);

    // Fill to full, one rejected push, drain in order
    for (int i = 0; i < 128; i++) step(1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd128);
    step(1'b1, 8'd200, 1'b0);
    check("over_push_ack", 32'(s_pa), 32'd0);
    check("over_we", 32'(s_we), 32'd0);
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 8'd0, 1'b1);
      check("drain_data", 32'(pop_data), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Pointer wrap from a fresh reset
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i * 3 + 1), 1'b0);
      check("wrap_adr", 32'(s_adr), 32'((100 + i) % 128));
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'd0, 1'b1);
      check("wrap_data", 32'(pop_data), 32'(i * 3 + 1));
    end

    // Simultaneous requests
    step(1'b1, 8'd5, 1'b0);
    step(1'b1, 8'd6, 1'b0);
    step(1'b1, 8'd77, 1'b1);
    check("both_ne_pop_ack", 32'(s_oa), 32'd1);
    check("both_ne_push_ack", 32'(s_pa), 32'd0);
    check("both_ne_we", 32'(s_we), 32'd0);
    check("both_ne_count", 32'(count), 32'd1);
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd77, 1'b1);
    check("both_e_push_ack", 32'(s_pa), 32'd1);
    check("both_e_pop_ack", 32'(s_oa), 32'd0);
    check("both_e_count", 32'(count), 32'd1);

    // Pop while empty
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    check("empty_pop_ack", 32'(s_oa), 32'd0);
    check("empty_pop_valid", 32'(pop_valid), 32'd0);

    // Randomized traffic: push-heavy, balanced, then pop-heavy
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 700; i++) begin
        step($urandom_range(0, 99) < (ph == 0 ? 80 : ph == 1 ? 50 : 20),
             8'($urandom),
             $urandom_range(0, 99) < (ph == 0 ? 25 : ph == 1 ? 50 : 80));
      end
    end

    // Asynchronous reset in the middle of a push
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 10), 1'b0);
    step(1'b0, 8'd0, 1'b1);
    push      = 1'b1;
    push_data = 8'd9;
    pop       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_pop_valid", 32'(pop_valid), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    @(posedge ck);
    #1;
    rst = 1'b0;
    step(1'b1, 8'd55, 1'b0);
    check("arst_first_adr", 32'(s_adr), 32'd0);
    check("arst_first_ack", 32'(s_pa), 32'd1);
    step(1'b0, 8'd0, 1'b1);
    check("arst_pop_data", 32'(pop_data), 32'd55);
    step(1'b0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
